// File: rtl/u2_ser_neg.sv
// Bit-serial two's-complement conditional negator: loads a word, streams the
// result LSB-first using copy-until-first-one-then-invert, then presents it in parallel.
module u2_ser_neg #(
    parameter int unsigned WIDTH = 5,
    parameter int unsigned CNTW  = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] din,
    input  logic             minus,
    output logic             busy,
    output logic             sout,
    output logic             sout_valid,
    output logic [WIDTH-1:0] dout,
    output logic             done,
    output logic             ovf
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_DONE
    } state_t;

    localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [CNTW-1:0]  LAST_BIT = CNTW'(WIDTH - 1);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] sh_q, sh_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [CNTW-1:0]  cnt_q, cnt_d;
    logic             m_q, m_d;
    logic             seen1_q, seen1_d;
    logic             ovf_pend_q, ovf_pend_d;
    logic             busy_q, busy_d;
    logic             sout_q, sout_d;
    logic             sout_valid_q, sout_valid_d;
    logic [WIDTH-1:0] dout_q, dout_d;
    logic             done_q, done_d;
    logic             ovf_q, ovf_d;

    logic             load;
    logic             cur_bit;
    logic             res_bit;

    always_comb begin
        state_d      = state_q;
        sh_d         = sh_q;
        res_d        = res_q;
        cnt_d        = cnt_q;
        m_d          = m_q;
        seen1_d      = seen1_q;
        ovf_pend_d   = ovf_pend_q;
        busy_d       = 1'b0;
        sout_d       = sout_q;
        sout_valid_d = 1'b0;
        dout_d       = dout_q;
        done_d       = 1'b0;
        ovf_d        = 1'b0;
        load         = 1'b0;

        // Bits up to and including the first 1 pass unchanged; later bits flip.
        cur_bit = sh_q[0];
        res_bit = (m_q & seen1_q) ? ~cur_bit : cur_bit;

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    load = 1'b1;
                end
            end
            S_SHIFT: begin
                busy_d       = 1'b1;
                sout_valid_d = 1'b1;
                sout_d       = res_bit;
                res_d        = {res_bit, res_q[WIDTH-1:1]};
                sh_d         = sh_q >> 1;
                seen1_d      = seen1_q | cur_bit;
                cnt_d        = cnt_q + CNTW'(1);
                if (cnt_q == LAST_BIT) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                done_d = 1'b1;
                dout_d = res_q;
                ovf_d  = ovf_pend_q;
                if (start) begin
                    load = 1'b1;
                end else begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (load) begin
            state_d    = S_SHIFT;
            sh_d       = din;
            m_d        = minus;
            ovf_pend_d = minus & (din == MOST_NEG);
            cnt_d      = '0;
            seen1_d    = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            sh_q         <= '0;
            res_q        <= '0;
            cnt_q        <= '0;
            m_q          <= 1'b0;
            seen1_q      <= 1'b0;
            ovf_pend_q   <= 1'b0;
            busy_q       <= 1'b0;
            sout_q       <= 1'b0;
            sout_valid_q <= 1'b0;
            dout_q       <= '0;
            done_q       <= 1'b0;
            ovf_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            sh_q         <= sh_d;
            res_q        <= res_d;
            cnt_q        <= cnt_d;
            m_q          <= m_d;
            seen1_q      <= seen1_d;
            ovf_pend_q   <= ovf_pend_d;
            busy_q       <= busy_d;
            sout_q       <= sout_d;
            sout_valid_q <= sout_valid_d;
            dout_q       <= dout_d;
            done_q       <= done_d;
            ovf_q        <= ovf_d;
        end
    end

    assign busy       = busy_q;
    assign sout       = sout_q;
    assign sout_valid = sout_valid_q;
    assign dout       = dout_q;
    assign done       = done_q;
    assign ovf        = ovf_q;

endmodule

// File: tb/tb_u2_ser_neg.sv
// Randomized self-checking bench for u2_ser_neg against an arithmetic model
// of modulo-2^W negation.
module tb_u2_ser_neg;

    localparam int W = 5;

    logic         clk;
    logic         rst;
    logic         start;
    logic [W-1:0] din;
    logic         minus;
    logic         busy;
    logic         sout;
    logic         sout_valid;
    logic [W-1:0] dout;
    logic         done;
    logic         ovf;

    int pass_cnt = 0;
    int chk_cnt  = 0;

    u2_ser_neg #(.WIDTH(W), .CNTW(3)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .din        (din),
        .minus      (minus),
        .busy       (busy),
        .sout       (sout),
        .sout_valid (sout_valid),
        .dout       (dout),
        .done       (done),
        .ovf        (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        chk_cnt++;
        if (got === exp) pass_cnt++;
        else $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    endtask

    function automatic int ref_result(input int d, input int m);
        int modv = 1 << W;
        return (m != 0) ? ((modv - d) % modv) : d;
    endfunction

    function automatic int ref_ovf(input int d, input int m);
        return ((m != 0) && (d == (1 << (W - 1)))) ? 1 : 0;
    endfunction

    task automatic launch(input int d, input int m);
        start = 1'b1;
        din   = W'(d);
        minus = 1'(m);
        @(negedge clk);
        start = 1'b0;
        check_eq("done_low_first", 32'(done), 0);
    endtask

    // Follows one word from its first serial bit to the done pulse; optionally
    // queues the next word during the DONE cycle or pokes start mid-shift.
    task automatic expect_word(input int d, input int m, input bit chain,
                               input int nd, input int nm, input bit poke);
        int exp_r;
        int exp_o;
        exp_r = ref_result(d, m);
        exp_o = ref_ovf(d, m);
        for (int i = 0; i < W; i++) begin
            @(negedge clk);
            check_eq("sout_valid", 32'(sout_valid), 1);
            check_eq("sout_bit", 32'(sout), (exp_r >> i) & 1);
            check_eq("busy", 32'(busy), 1);
            check_eq("done_mid", 32'(done), 0);
            din   = W'($urandom_range(0, (1 << W) - 1));
            minus = 1'($urandom_range(0, 1));
            if (poke && i == 0) begin
                start = 1'b1;
                din   = '1;
            end else begin
                start = 1'b0;
            end
            if (chain && i == W - 1) begin
                start = 1'b1;
                din   = W'(nd);
                minus = 1'(nm);
            end
        end
        @(negedge clk);
        check_eq("done", 32'(done), 1);
        check_eq("dout", 32'(dout), exp_r);
        check_eq("ovf", 32'(ovf), exp_o);
        check_eq("sout_valid_end", 32'(sout_valid), 0);
        check_eq("busy_end", 32'(busy), 0);
        start = 1'b0;
        if (!chain) begin
            @(negedge clk);
            check_eq("done_pulse_width", 32'(done), 0);
            check_eq("idle_busy", 32'(busy), 0);
            check_eq("dout_hold", 32'(dout), exp_r);
            check_eq("ovf_low_idle", 32'(ovf), 0);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        int dl [64];
        int ml [64];
        bit cl [64];
        bit chained_in;
        int tmp;
        int j2;

        rst   = 1'b1;
        start = 1'b0;
        din   = '0;
        minus = 1'b0;
        #1;
        check_eq("rst_busy", 32'(busy), 0);
        check_eq("rst_sout_valid", 32'(sout_valid), 0);
        check_eq("rst_done", 32'(done), 0);
        check_eq("rst_dout", 32'(dout), 0);
        check_eq("rst_ovf", 32'(ovf), 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        launch(6, 1);
        expect_word(6, 1, 1'b0, 0, 0, 1'b0);
        launch(22, 0);
        expect_word(22, 0, 1'b0, 0, 0, 1'b0);
        launch(16, 1);
        expect_word(16, 1, 1'b1, 0, 1, 1'b0);
        expect_word(0, 1, 1'b0, 0, 0, 1'b0);

        // start during SHIFT ignored, then a word accepted in the DONE cycle
        launch(9, 1);
        expect_word(9, 1, 1'b1, 1, 1, 1'b1);
        expect_word(1, 1, 1'b0, 0, 0, 1'b0);

        // asynchronous reset in the third SHIFT cycle
        launch(13, 1);
        @(negedge clk);
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check_eq("amid_busy", 32'(busy), 0);
        check_eq("amid_sout", 32'(sout), 0);
        check_eq("amid_sout_valid", 32'(sout_valid), 0);
        check_eq("amid_done", 32'(done), 0);
        check_eq("amid_dout", 32'(dout), 0);
        check_eq("amid_ovf", 32'(ovf), 0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < W + 2; i++) begin
            @(negedge clk);
            check_eq("no_done_after_abort", 32'(done), 0);
            check_eq("no_busy_after_abort", 32'(busy), 0);
        end
        launch(3, 1);
        expect_word(3, 1, 1'b0, 0, 0, 1'b0);

        // full sweep in shuffled order with random back-to-back chaining
        for (int i = 0; i < 64; i++) begin
            dl[i] = i % 32;
            ml[i] = i / 32;
        end
        for (int i = 63; i > 0; i--) begin
            j2 = $urandom_range(0, i);
            tmp = dl[i]; dl[i] = dl[j2]; dl[j2] = tmp;
            tmp = ml[i]; ml[i] = ml[j2]; ml[j2] = tmp;
        end
        for (int i = 0; i < 64; i++) cl[i] = (i < 63) ? 1'($urandom_range(0, 1)) : 1'b0;
        chained_in = 1'b0;
        for (int i = 0; i < 64; i++) begin
            if (!chained_in) launch(dl[i], ml[i]);
            expect_word(dl[i], ml[i], cl[i],
                        (i < 63) ? dl[(i + 1) % 64] : 0,
                        (i < 63) ? ml[(i + 1) % 64] : 0, 1'b0);
            chained_in = cl[i];
        end

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
